// File: rtl/risc_pkg.sv
// risc_pkg: shared widths, fetch-stage state encoding and NOP word for the KGP_RISC front end.
package risc_pkg;
  localparam int unsigned PC_W   = 10;
  localparam int unsigned INST_W = 32;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t IDLE = 2'd0;
  localparam fetch_state_t REQ  = 2'd1;
  localparam fetch_state_t WAIT = 2'd2;
  localparam fetch_state_t HOLD = 2'd3;

  // All-zero word decodes as a no-op; also the idle value of the instruction register.
  localparam logic [INST_W-1:0] NOP = '0;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry slot holding a prefetched word + npc while IF_ID is stalled.
// Only present when FETCH_SKID_EN is defined.
`ifdef FETCH_SKID_EN
module fetch_skid_buf
  import risc_pkg::NOP;
#(
  parameter int unsigned PC_W   = risc_pkg::PC_W,
  parameter int unsigned INST_W = risc_pkg::INST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [INST_W-1:0] push_inst,
  input  logic [PC_W-1:0]   push_npc,
  input  logic              pop,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   npc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      inst  <= INST_W'(NOP);
      npc   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      inst  <= push_inst;
      npc   <= push_npc;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/instr_fetch.sv
// instr_fetch: KGP_RISC fetch stage feeding IF_ID; one outstanding imem fetch, stall/redirect aware.
// Define FETCH_SKID_EN to add a one-entry skid buffer that keeps fetching under a stall.
module instr_fetch
  import risc_pkg::fetch_state_t, risc_pkg::IDLE, risc_pkg::REQ, risc_pkg::WAIT,
         risc_pkg::HOLD, risc_pkg::NOP;
#(
  parameter int unsigned     PC_W     = risc_pkg::PC_W,
  parameter int unsigned     INST_W   = risc_pkg::INST_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   npc_out
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic            drop;
  logic            consume;
  logic            accept;
  logic            load_out;

  assign imem_req  = (state == REQ);
  assign imem_addr = imem_req ? pc : '0;
  assign pc_inc    = pc + PC_W'(1);
  assign consume   = inst_valid & ~stall_in;
  assign accept    = (state == WAIT) & imem_rvalid & ~drop;
  // A fresh word goes straight to the outputs if they are empty or being drained this edge.
  assign load_out  = accept & (~inst_valid | consume);

`ifdef FETCH_SKID_EN
  logic              skid_valid;
  logic              skid_push;
  logic              skid_pop;
  logic [INST_W-1:0] skid_inst;
  logic [PC_W-1:0]   skid_npc;

  assign skid_push = ~redirect_valid & accept & ~load_out;
  assign skid_pop  = ~redirect_valid & consume & skid_valid;

  fetch_skid_buf #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (skid_push),
    .push_inst (imem_rdata),
    .push_npc  (pc_inc),
    .pop       (skid_pop),
    .valid     (skid_valid),
    .inst      (skid_inst),
    .npc       (skid_npc)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst_out   <= INST_W'(NOP);
      npc_out    <= '0;
    end else if (redirect_valid) begin
      pc         <= redirect_pc;
      inst_valid <= 1'b0;
      // A fetch issued but not yet answered must have its response swallowed.
      if (state == REQ || (state == WAIT && !imem_rvalid)) begin
        drop  <= 1'b1;
        state <= WAIT;
      end else begin
        drop  <= 1'b0;
        state <= REQ;
      end
    end else begin
      if (load_out) begin
        inst_out   <= imem_rdata;
        npc_out    <= pc_inc;
        inst_valid <= 1'b1;
      end
`ifdef FETCH_SKID_EN
      else if (skid_pop) begin
        inst_out   <= skid_inst;
        npc_out    <= skid_npc;
        inst_valid <= 1'b1;
      end
`endif
      else if (consume) begin
        inst_valid <= 1'b0;
      end

      case (state)
        IDLE: state <= REQ;
        REQ:  state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              pc    <= pc_inc;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
`ifdef FETCH_SKID_EN
          if (!skid_valid) state <= REQ;
`else
          if (!stall_in) state <= REQ;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a sequence-level fetch model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [9:0]  npc_out;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  logic [31:0] mem [1024];
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  bit          pend    = 1'b0;
  int unsigned pend_due;
  logic [31:0] pend_data;

  always #5 clk = ~clk;

  instr_fetch #(
    .PC_W     (10),
    .INST_W   (32),
    .RESET_PC (10'd0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .npc_out        (npc_out)
  );

  // Advance to the middle of the next cycle and play the instruction memory for that cycle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (imem_req) begin
      pend      = 1'b1;
      pend_due  = cyc + $urandom_range(lat_max, lat_min);
      pend_data = mem[imem_addr];
    end
    if (pend && pend_due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_data;
      pend        = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rvalid    = 1'b0;
    pend           = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic run_until_valid(input int unsigned bound, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < bound && !ok; i++) begin
      tick();
      if (inst_valid) ok = 1'b1;
    end
  endtask

  task automatic run_until_req(input int unsigned bound, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < bound && !ok; i++) begin
      tick();
      if (imem_req) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [9:0]  addrs[$];
    int unsigned rc[$];
    bit          got;
    logic [31:0] fi;
    logic [9:0]  fn;
    lat_min = 1; lat_max = 1;
    stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; pend = 1'b0;
    reset = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 10'd0 ||
          inst_out !== 32'd0 || npc_out !== 10'd0) begin
        errors++;
        $display("FAIL reset_state: valid=%b req=%b addr=%h inst=%h npc=%h, required all 0",
                 inst_valid, imem_req, imem_addr, inst_out, npc_out);
      end
    end
    reset = 1'b1;
    got = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      tick();
      if (imem_req) begin
        addrs.push_back(imem_addr);
        rc.push_back(cyc);
      end
      if (inst_valid && !got) begin
        got = 1'b1; fi = inst_out; fn = npc_out;
      end
    end
    checks++;
    if (addrs.size() < 3) begin
      errors++;
      $display("FAIL reset_req_count: got %0d requests, required >= 3", addrs.size());
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        checks++;
        if (addrs[i] !== 10'(i)) begin
          errors++;
          $display("FAIL reset_req_addr%0d: got %h required %h", i, addrs[i], 10'(i));
        end
      end
      checks++;
      if (rc[1] - rc[0] != 3) begin
        errors++;
        $display("FAIL reset_cadence: got %0d cycles between fetches, required 3", rc[1] - rc[0]);
      end
    end
    checks++;
    if (!got || fi !== mem[0] || fn !== 10'd1) begin
      errors++;
      $display("FAIL reset_first_inst: got valid=%b inst=%h npc=%h, required inst=%h npc=001",
               got, fi, fn, mem[0]);
    end
  endtask

  task automatic test_stall();
    bit          ok;
    logic [31:0] si;
    logic [9:0]  sn;
    int unsigned nreq, exp_req, c0;
    logic [9:0]  sn1;
`ifdef FETCH_SKID_EN
    exp_req = 1;
`else
    exp_req = 0;
`endif
    lat_min = 1; lat_max = 1;
    do_reset();
    run_until_valid(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_reach: no valid instruction within 20 cycles, required one");
    end else begin
      si = inst_out; sn = npc_out; nreq = 0;
      stall_in = 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
        if (i > 0) tick();
        checks++;
        if (inst_valid !== 1'b1 || inst_out !== si || npc_out !== sn) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b inst=%h npc=%h, required 1 %h %h",
                   inst_valid, inst_out, npc_out, si, sn);
        end
        if (imem_req) nreq++;
      end
      checks++;
      if (nreq != exp_req) begin
        errors++;
        $display("FAIL stall_req_count: got %0d requests, required %0d", nreq, exp_req);
      end
      stall_in = 1'b0;
      c0 = cyc;
      sn1 = sn + 10'd1;
      run_until_valid(20, ok);
      checks++;
      if (!ok || inst_out !== mem[sn] || npc_out !== sn1) begin
        errors++;
        $display("FAIL stall_next_inst: got valid=%b inst=%h npc=%h, required %h %h",
                 ok, inst_out, npc_out, mem[sn], sn1);
      end
`ifdef FETCH_SKID_EN
      checks++;
      if (cyc - c0 != 1) begin
        errors++;
        $display("FAIL skid_release_latency: got %0d cycles, required 1", cyc - c0);
      end
`endif
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    lat_min = 3; lat_max = 3;
    do_reset();
    run_until_req(10, ok);
    tick();
    redirect_valid = 1'b1; redirect_pc = 10'd40;
    tick();
    redirect_valid = 1'b0;
    run_until_req(10, ok);
    checks++;
    if (!ok || imem_addr !== 10'd40) begin
      errors++;
      $display("FAIL redir_wait_addr: got req=%b addr=%h, required 1 028", ok, imem_addr);
    end
    run_until_valid(10, ok);
    checks++;
    if (!ok || npc_out !== 10'd41 || inst_out !== mem[40]) begin
      errors++;
      $display("FAIL redir_wait_inst: got valid=%b inst=%h npc=%h, required %h 029",
               ok, inst_out, npc_out, mem[40]);
    end
  endtask

  task automatic test_redirect_stall_hold();
    bit         ok;
    logic [9:0] r, r1;
    lat_min = 1; lat_max = 1;
    do_reset();
    run_until_valid(20, ok);
    r = 10'd100 + 10'($urandom_range(200, 0));
    r1 = r + 10'd1;
    stall_in = 1'b1; redirect_valid = 1'b1; redirect_pc = r;
    tick();
    stall_in = 1'b0; redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_stall_valid: got %b, required 0", inst_valid);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== r) begin
      errors++;
      $display("FAIL redir_stall_fetch: got req=%b addr=%h, required 1 %h", imem_req, imem_addr, r);
    end
    run_until_valid(10, ok);
    checks++;
    if (!ok || npc_out !== r1 || inst_out !== mem[r]) begin
      errors++;
      $display("FAIL redir_stall_inst: got valid=%b inst=%h npc=%h, required %h %h",
               ok, inst_out, npc_out, mem[r], r1);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    lat_min = 1; lat_max = 1;
    do_reset();
    run_until_valid(20, ok);
    redirect_valid = 1'b1; redirect_pc = 10'h3FF;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'h3FF) begin
      errors++;
      $display("FAIL wrap_fetch: got req=%b addr=%h, required 1 3ff", imem_req, imem_addr);
    end
    run_until_valid(10, ok);
    checks++;
    if (!ok || npc_out !== 10'h000 || inst_out !== mem[1023]) begin
      errors++;
      $display("FAIL wrap_npc: got valid=%b inst=%h npc=%h, required %h 000",
               ok, inst_out, npc_out, mem[1023]);
    end
    run_until_req(10, ok);
    checks++;
    if (!ok || imem_addr !== 10'h000) begin
      errors++;
      $display("FAIL wrap_next_addr: got req=%b addr=%h, required 1 000", ok, imem_addr);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    lat_min = 3; lat_max = 3;
    do_reset();
    run_until_valid(20, ok);
    run_until_req(20, ok);
    tick();
    #1 reset = 1'b0;
    pend = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 10'd0 ||
        inst_out !== 32'd0 || npc_out !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b req=%b addr=%h inst=%h npc=%h, required all 0",
               inst_valid, imem_req, imem_addr, inst_out, npc_out);
    end
    repeat (2) tick();
    reset = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    run_until_req(10, ok);
    checks++;
    if (!ok || imem_addr !== 10'd0) begin
      errors++;
      $display("FAIL restart_addr: got req=%b addr=%h, required 1 000", ok, imem_addr);
    end
    run_until_valid(10, ok);
    checks++;
    if (!ok || inst_out !== mem[0] || npc_out !== 10'd1) begin
      errors++;
      $display("FAIL restart_inst: got valid=%b inst=%h npc=%h, required %h 001",
               ok, inst_out, npc_out, mem[0]);
    end
  endtask

  // Sequence model: the k-th delivered word after a redirect to R is mem[R+k] with npc R+k+1,
  // and the k-th fetch issued after it targets R+k.
  task automatic test_random();
    logic [9:0]  exp_next, req_exp, en1;
    int unsigned consumed, last_act;
    bit          prev_hold;
    logic [31:0] hold_i;
    logic [9:0]  hold_n;
    lat_min = 1; lat_max = 3;
    do_reset();
    exp_next = '0; req_exp = '0; consumed = 0; last_act = cyc; prev_hold = 1'b0;
    hold_i = '0; hold_n = '0;
    for (int unsigned i = 0; i < 3000; i++) begin
      tick();
      if (prev_hold) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_out !== hold_i || npc_out !== hold_n) begin
          errors++;
          $display("FAIL rand_hold @%0d: got valid=%b inst=%h npc=%h, required 1 %h %h",
                   cyc, inst_valid, inst_out, npc_out, hold_i, hold_n);
        end
      end
      if (imem_req) begin
        checks++;
        if (imem_addr !== req_exp) begin
          errors++;
          $display("FAIL rand_req_addr @%0d: got %h required %h", cyc, imem_addr, req_exp);
        end
        req_exp  = req_exp + 10'd1;
        last_act = cyc;
      end
      stall_in       = ($urandom_range(99, 0) < 35);
      redirect_valid = ($urandom_range(99, 0) < 3);
      redirect_pc    = 10'($urandom);
      if (!imem_rvalid && !pend && $urandom_range(99, 0) < 10) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end
      if (inst_valid && !stall_in) begin
        en1 = exp_next + 10'd1;
        checks++;
        if (inst_out !== mem[exp_next] || npc_out !== en1) begin
          errors++;
          $display("FAIL rand_consume @%0d: got inst=%h npc=%h, required %h %h",
                   cyc, inst_out, npc_out, mem[exp_next], en1);
        end
        exp_next = en1;
        consumed++;
        last_act = cyc;
      end
      if (redirect_valid) begin
        exp_next = redirect_pc;
        req_exp  = redirect_pc;
      end
      prev_hold = inst_valid && stall_in && !redirect_valid;
      hold_i = inst_out;
      hold_n = npc_out;
      if (cyc - last_act > 60) begin
        checks++;
        errors++;
        $display("FAIL rand_watchdog @%0d: no fetch or delivery for 60 cycles", cyc);
        break;
      end
    end
    stall_in = 1'b0; redirect_valid = 1'b0;
    checks++;
    if (consumed < 150) begin
      errors++;
      $display("FAIL rand_progress: got %0d deliveries, required >= 150", consumed);
    end
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    for (int unsigned i = 0; i < 1024; i++) mem[i] = $urandom;
    #2;
    test_reset();
    test_stall();
    test_redirect_wait();
    test_redirect_stall_hold();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
